// File: rtl/tristate_arb_pkg.sv
// rtl/tristate_arb_pkg.sv - shared state encoding, width helper and parameter checks for the tri-state bus arbiter
package tristate_arb_pkg;

    // FSM encoding kept as plain 2-bit constants so older tools and netlists can decode it
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    // Bits needed to hold an index 0..n-1; never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Elaboration-time sanity of the configuration
    function automatic bit params_ok(input int n, input int turn_cyc, input int max_burst);
        return (n >= 2) && (n <= 16) && (turn_cyc >= 1) && (max_burst >= 0);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational next-owner picker (round-robin, or fixed priority with TRISTATE_ARB_FIXED_PRIO_EN)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

`ifdef TRISTATE_ARB_FIXED_PRIO_EN
    // The pointer is meaningless when the lowest index always wins
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan from the top down so the lowest requesting index is the last one written
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end
`else
    int cand;

    // Walk N positions starting at ptr, wrapping N-1 -> 0, and take the first requester
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end
`endif

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - N-channel tri-state bus owner FSM with burst cap and turnaround (option: TRISTATE_ARB_FIXED_PRIO_EN)
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            reqIn,
    input  logic [N*W-1:0]          dataIn,
    output logic [N-1:0]            gntOut,
    output logic [W-1:0]            busOut,
    output logic                    busEnb,
    output logic [id_width(N)-1:0]  ownerId
);

    localparam int IW = id_width(N);
    localparam int BW = id_width(MAX_BURST + 1);
    localparam int TW = id_width(TURN_CYC + 1);

    if (!params_ok(N, TURN_CYC, MAX_BURST)) begin : g_bad_params
        $error("tristate_bus_arbiter: N must be 2..16 and TURN_CYC >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [IW-1:0] pick_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          arb;
    logic          owner_drop;
    logic          burst_cap;
    logic [IW-1:0] owner_next;
    logic [W-1:0]  bus_sel;

`ifdef TRISTATE_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (reqIn),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Release causes: owner lets go, or it has used its full burst allowance
    assign owner_drop = !reqIn[owner_q];
    assign burst_cap  = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST));
    assign owner_next = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

    // Next-state logic: arbitrate from IDLE or at the end of turnaround, count burst and gap cycles
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        turn_d   = turn_q;
        arb      = 1'b0;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                arb = 1'b1;
            end
            DRIVE: begin
                if (owner_drop || burst_cap) begin
                    state_d  = TURN;
                    gnt_d    = '0;
                    turn_d   = TW'(1);
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
                    // The owner just served goes to the back of the queue
                    rr_ptr_d = owner_next;
`endif
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q < TW'(TURN_CYC)) begin
                    turn_d = turn_q + 1'b1;
                end else begin
                    arb = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (arb) begin
            if (pick_found) begin
                state_d = DRIVE;
                gnt_d   = N'(1) << pick_idx;
                owner_d = pick_idx;
                burst_d = BW'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    // State registers; reset drops the bus immediately with no turnaround owed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
            turn_q   <= '0;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            turn_q   <= turn_d;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // One-hot AND-OR mux of the granted channel's data, zero delay from dataIn
    always_comb begin
        bus_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                bus_sel = bus_sel | dataIn[i*W +: W];
            end
        end
    end

    assign gntOut  = gnt_q;
    assign busEnb  = |gnt_q;
    assign ownerId = owner_q;
    assign busOut  = busEnb ? bus_sel : {W{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - table-driven self-checking bench for tristate_bus_arbiter (N=4, W=8, MAX_BURST=4, TURN_CYC=1)
module tb_tristate_bus_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic [7:0]  bus;
    } vec_t;

    localparam logic [31:0] D  = 32'h44A5_2211;
    localparam logic [31:0] D2 = 32'h445A_2211;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt_out;
    wire  [7:0]  bus_out;
    logic        bus_enb;
    logic [1:0]  owner_id;

    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    tristate_bus_arbiter #(
        .W         (8),
        .N         (4),
        .MAX_BURST (4),
        .TURN_CYC  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .reqIn   (req),
        .dataIn  (data),
        .gntOut  (gnt_out),
        .busOut  (bus_out),
        .busEnb  (bus_enb),
        .ownerId (owner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void add(input logic r, input logic [3:0] q, input logic [31:0] d,
                                input logic [3:0] g, input logic [1:0] o, input logic [7:0] b);
        vec_t v;
        v.rst = r; v.req = q; v.data = d; v.gnt = g; v.own = o; v.bus = b;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_edge(input logic r, input logic [3:0] q, input logic [31:0] d);
        @(negedge clk);
        rst  = r;
        req  = q;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] o, input logic [7:0] b);
        chk({tag, " gnt"}, 32'(gnt_out), 32'(g));
        chk({tag, " enb"}, 32'(bus_enb), 32'(|g));
        chk({tag, " own"}, 32'(owner_id), 32'(o));
        chk({tag, " onehot"}, 32'($onehot0(gnt_out)), 32'd1);
        if (g != 4'b0) begin
            chk({tag, " bus"}, 32'(bus_out), 32'(b));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        req  = 4'h0;
        data = D;

        // Reset held with everyone requesting: no grant may escape
        add(1, 4'hF, D, 4'b0000, 0, 8'h00);
        add(1, 4'hF, D, 4'b0000, 0, 8'h00);
`ifdef TRISTATE_ARB_FIXED_PRIO_EN
        // ch0 always wins over ch3: 4 on, 1 Z, repeat
        for (int i = 0; i < 10; i++) begin
            add(0, 4'b1001, D, ((i % 5) < 4) ? 4'b0001 : 4'b0000, 0, 8'h11);
        end
        add(0, 4'b0000, D, 4'b0000, 0, 8'h00);
        add(0, 4'b0000, D, 4'b0000, 0, 8'h00);
`else
        // All requesting: ch0..ch3 then ch0, 4 cycles each with one Z gap
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                add(0, 4'hF, D, 4'b0001 << c, 2'(c), D[c*8 +: 8]);
            end
            add(0, 4'hF, D, 4'b0000, 2'(c), 8'h00);
        end
        add(0, 4'hF, D, 4'b0001, 0, 8'h11);
        add(0, 4'h0, D, 4'b0000, 0, 8'h00);
        add(0, 4'h0, D, 4'b0000, 0, 8'h00);
        add(0, 4'h0, D, 4'b0000, 0, 8'h00);
        // Single requester ch2, data change visible with zero latency, then drop
        add(0, 4'b0100, D,  4'b0100, 2, 8'hA5);
        add(0, 4'b0100, D2, 4'b0100, 2, 8'h5A);
        add(0, 4'b0000, D,  4'b0000, 2, 8'h00);
        add(0, 4'b0000, D,  4'b0000, 2, 8'h00);
        add(0, 4'b0000, D,  4'b0000, 2, 8'h00);
        // ch3 owns, drops early; pointer wraps so ch0 beats ch1; ch1 dropping is ignored
        add(0, 4'b1011, D, 4'b1000, 3, 8'h44);
        add(0, 4'b1011, D, 4'b1000, 3, 8'h44);
        add(0, 4'b0011, D, 4'b0000, 3, 8'h00);
        add(0, 4'b0011, D, 4'b0001, 0, 8'h11);
        add(0, 4'b0001, D, 4'b0001, 0, 8'h11);
        add(0, 4'b0011, D, 4'b0001, 0, 8'h11);
        // ch1 in its second burst cycle, reset pulse, arbitration restarts at ch0 with no gap
        add(0, 4'b0010, D, 4'b0000, 0, 8'h00);
        add(0, 4'b0010, D, 4'b0010, 1, 8'h22);
        add(0, 4'b0010, D, 4'b0010, 1, 8'h22);
        add(1, 4'b0010, D, 4'b0000, 0, 8'h00);
        add(0, 4'b0011, D, 4'b0001, 0, 8'h11);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].rst, vecs[i].req, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].own, vecs[i].bus);
        end

        // Lone requester holding on: 4 granted, 1 Z, repeating
        drive_edge(1'b1, 4'b0100, D);
        check_out("solo_rst", 4'b0000, 0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            drive_edge(1'b0, 4'b0100, D);
            check_out($sformatf("solo%0d", i), ((i % 5) < 4) ? 4'b0100 : 4'b0000, 2, 8'hA5);
        end
        drive_edge(1'b0, 4'b0000, D);
        check_out("solo_drop", 4'b0000, 2, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Parametrised successor to the single-driver tri-state buffer: N channels share one W-bit tri-state bus.
- Only one channel drives the bus at a time; all other cycles the bus is released to high-Z.
- Ownership is granted round-robin, bursts are capped, and a high-Z turnaround gap is enforced between owners so two drivers never overlap.
- Sits between peripheral channel sources and a shared board/internal bus.

Parameters:
- W, 8, data width per channel and of the bus.
- N, 4, number of channels (2..16).
- MAX_BURST, 4, maximum consecutive cycles one owner may drive; 0 = unlimited.
- TURN_CYC, 1, high-Z turnaround cycles after each release (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- reqIn  input  N  per-channel bus request, level.
- dataIn  input  N*W  channel i data in bits [i*W+W-1 : i*W].
- gntOut  output  N  registered one-hot grant; all-zero when nobody owns the bus.
- busOut  output  W  shared bus: dataIn slice of the owner while granted, else all 'z'.
- busEnb  output  1  active high; equals |gntOut.
- ownerId  output  clog2(N)  index of the current/last owner.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset state at the clk edge with rst=1: state IDLE, gntOut=0, busEnb=0, busOut=all z, ownerId=0, rrPtr=0, burstCnt=0, turnCnt=0.
- States:
  - IDLE: if reqIn!=0, pick the first requesting channel searching from rrPtr upward with wrap N-1 -> 0. Next cycle: gntOut=onehot(pick), ownerId=pick, state DRIVE, burstCnt=1. If reqIn==0, stay in IDLE.
  - DRIVE: release when reqIn[ownerId] is sampled 0, or when burstCnt==MAX_BURST (MAX_BURST!=0). Otherwise stay in DRIVE and increment burstCnt.
  - Release actions: next cycle gntOut=0, busEnb=0, rrPtr=(ownerId+1) mod N, turnCnt=1, state TURN.
  - TURN: bus is high-Z. If turnCnt<TURN_CYC, increment turnCnt. If turnCnt==TURN_CYC, arbitrate exactly as in IDLE; go to DRIVE (grant next cycle) if any request is pending, else go to IDLE.
- Timing:
  - Grant latency from IDLE is 1 cycle: reqIn high at edge k gives gntOut high after edge k.
  - Back-to-back owners are separated by exactly TURN_CYC high-Z cycles.
  - A capped owner whose request is still asserted re-enters arbitration with the lowest priority.
- Data path:
  - busOut is combinational from the registered grant: busOut = busEnb ? dataIn[ownerId] : {W{1'bz}}.
  - Zero latency from dataIn to busOut while granted.
- Invariants:
  - gntOut is always one-hot or zero.
  - busEnb==|gntOut.
  - No cycle has a grant in TURN or IDLE.
- Boundaries:
  - rrPtr wraps N-1 -> 0.
  - A single requester holding reqIn with MAX_BURST=4 gets 4 cycles granted, TURN_CYC cycles Z, then 4 more cycles, repeating.
  - Requests raised during DRIVE or TURN are not lost; they are seen at the next arbitration.
  - A non-owner dropping its request has no effect.
  - rst asserted mid-DRIVE: bus goes high-Z and gntOut=0 after that edge; no turnaround is required after reset.
  - MAX_BURST=0: release only on request drop.

Optional Feature:
- Macro TRISTATE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, the lowest-index requester always wins; rrPtr is not implemented. The burst cap and turnaround still apply.
- Undefined: round-robin as described above.

Decomposition:
- Package tristate_arb_pkg holds:
  - state encoding localparams IDLE=2'd0, DRIVE=2'd1, TURN=2'd2;
  - a clog2-based ID-width function;
  - parameter legality checks (N>=2, TURN_CYC>=1).
- One combinational sub-module, rr_pick: inputs req[N], ptr; outputs found and idx. Its fixed-priority variant is selected by the macro.
- The top level contains the FSM, counters, and the tri-state bus mux.

Test Plan (N=4, W=8, MAX_BURST=4, TURN_CYC=1):
- Reset: rst=1 for 2 cycles with reqIn=4'hF -> gntOut=0, busOut=8'hzz, busEnb=0 throughout; first grant is ch0 one cycle after rst falls.
- Single request: reqIn=4'b0100, dataIn ch2=8'hA5 -> after 1 cycle gntOut=4'b0100, busOut=8'hA5. reqIn dropped -> next cycle busOut=8'hzz; 1 TURN cycle, then IDLE.
- All requesting: reqIn=4'hF held -> grant order ch0, ch1, ch2, ch3, ch0. Each owner holds exactly 4 cycles, each burst is followed by exactly 1 cycle of 8'hzz, and gntOut is never multi-hot.
- Early release plus wrap: ch3 owner drops after 2 cycles with ch0 and ch1 requesting -> ch0 granted after 1 Z cycle (rrPtr wrapped to 0).
- Reset mid-DRIVE: ch1 in its 2nd burst cycle, pulse rst for 1 cycle -> next cycle busOut=8'hzz, gntOut=0, ownerId=0; arbitration restarts from ch0.
- With TRISTATE_ARB_FIXED_PRIO_EN and reqIn=4'b1001 held -> ch0 repeatedly wins (4 on, 1 Z); ch3 never granted.
